// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe
//
// Hazard control for a five-stage in-order pipeline that also has a
// multicycle multiply/divide unit in the execute stage.
//
// Parameters
//   REGW    register-address width
//   MDLAT   multiply/divide execute latency in cycles (2..16)
//   CNTW    width of the stall-cycle counter
//   ZEROREG 1 = register 0 is hardwired and never matches
//
// Ports
//   clk, reset                       rising-edge clock, async active-high reset
//   rsD, rtD                         decode-stage source addresses
//   rsE, rtE, writeregE              execute-stage sources and destination
//   writeregM, writeregW             memory/writeback destinations
//   regwriteE/M/W                    per-stage register-write enables
//   memtoregE, memtoregM             load in E / load in M
//   branchD                          branch compare active in decode
//   mdstartE                         multicycle op occupies execute
//   clrcnt                           synchronous clear of stallcnt
//   stallF, stallD, stallE           hold the F/D/E pipeline registers
//   flushE, flushM                   bubble into the E/M register
//   forwardAD, forwardBD             1 = aluoutM to the decode comparator
//   forwardAE, forwardBE             00 regfile, 01 resultW, 10 aluoutM
//   mdbusy, mddone                   multicycle unit holding / release pulse
//   stallcnt                         saturating count of stallF cycles
module hazard_ctrl_pipe #(
    parameter int REGW    = 5,
    parameter int MDLAT   = 4,
    parameter int CNTW    = 16,
    parameter int ZEROREG = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] rsD,
    input  logic [REGW-1:0] rtD,
    input  logic [REGW-1:0] rsE,
    input  logic [REGW-1:0] rtE,
    input  logic [REGW-1:0] writeregE,
    input  logic [REGW-1:0] writeregM,
    input  logic [REGW-1:0] writeregW,
    input  logic            regwriteE,
    input  logic            regwriteM,
    input  logic            regwriteW,
    input  logic            memtoregE,
    input  logic            memtoregM,
    input  logic            branchD,
    input  logic            mdstartE,
    input  logic            clrcnt,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            flushE,
    output logic            flushM,
    output logic            forwardAD,
    output logic            forwardBD,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            mdbusy,
    output logic            mddone,
    output logic [CNTW-1:0] stallcnt
);

    localparam int              MDCW   = (MDLAT > 1) ? $clog2(MDLAT) : 1;
    localparam logic [MDCW-1:0] MDLOAD = MDCW'(MDLAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdState_t;

    mdState_t        mdState;
    logic [MDCW-1:0] mdCnt;
    logic            mdStall;
    logic            lwStall;
    logic            brStall;

    // Address compare; register 0 is a constant source when ZEROREG is set,
    // so a write to it must never create a dependence.
    function automatic logic regMatch(input logic [REGW-1:0] a,
                                      input logic [REGW-1:0] b);
        return (a == b) && !((ZEROREG != 0) && (a == '0));
    endfunction

    function automatic logic [CNTW-1:0] satInc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [REGW-1:0] src);
        if (regwriteM && regMatch(src, writeregM))
            return 2'b10;
        else if (regwriteW && regMatch(src, writeregW))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Forwarding: M is newer than W, so it wins.
    assign forwardAE = fwdSel(rsE);
    assign forwardBE = fwdSel(rtE);
    assign forwardAD = regwriteM && regMatch(rsD, writeregM);
    assign forwardBD = regwriteM && regMatch(rtD, writeregM);

    // Load-use: the loaded value is not available until after M.
    assign lwStall = memtoregE && (regMatch(rtE, rsD) || regMatch(rtE, rtD));

    // Branch compare in D needs operands that are still in E, or a load in M.
    assign brStall = branchD &&
                     ((regwriteE && (regMatch(writeregE, rsD) || regMatch(writeregE, rtD))) ||
                      (memtoregM && (regMatch(writeregM, rsD) || regMatch(writeregM, rtD))));

    // The start cycle itself stalls, then MDLAT-1 more cycles while the
    // counter runs down; the counter==0 cycle is the release cycle.
    always_comb begin
        mdStall = 1'b0;
        mddone  = 1'b0;
        if (mdState == IDLE) begin
            mdStall = mdstartE;
        end else if (mdCnt != '0) begin
            mdStall = 1'b1;
        end else begin
            mddone = 1'b1;
        end
    end

    assign mdbusy = mdStall;
    assign stallF = lwStall | brStall | mdStall;
    assign stallD = stallF;
    assign stallE = mdStall;
    assign flushM = mdStall;
    // While E is held there must be no bubble into E, or the held op is lost.
    assign flushE = (lwStall | brStall) & ~mdStall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdState <= IDLE;
            mdCnt   <= '0;
        end else if (mdState == IDLE) begin
            if (mdstartE) begin
                mdCnt   <= MDLOAD;
                mdState <= BUSY;
            end
        end else begin
            if (mdCnt != '0)
                mdCnt <= mdCnt - 1'b1;
            else
                mdState <= IDLE;
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stallcnt <= '0;
        else if (clrcnt)
            stallcnt <= '0;
        else if (stallF)
            stallcnt <= satInc(stallcnt);
    end

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed bench for hazard_ctrl_pipe (MDLAT=4, CNTW=4, ZEROREG=1).
// Expected outputs come from a behavioural model of the hazard rules and
// of the multiply/divide op as a cycle-of-operation phase; they are queued
// when inputs are applied and popped when the outputs are sampled.
module tb_hazard_ctrl_pipe;

    localparam int REGW  = 5;
    localparam int MDLAT = 4;
    localparam int CNTW  = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [REGW-1:0] rsD = '0, rtD = '0, rsE = '0, rtE = '0;
    logic [REGW-1:0] writeregE = '0, writeregM = '0, writeregW = '0;
    logic            regwriteE = 1'b0, regwriteM = 1'b0, regwriteW = 1'b0;
    logic            memtoregE = 1'b0, memtoregM = 1'b0, branchD = 1'b0;
    logic            mdstartE = 1'b0, clrcnt = 1'b0;
    logic            stallF, stallD, stallE, flushE, flushM;
    logic            forwardAD, forwardBD, mdbusy, mddone;
    logic [1:0]      forwardAE, forwardBE;
    logic [CNTW-1:0] stallcnt;

    always #5 clk = ~clk;

    hazard_ctrl_pipe #(.REGW(REGW), .MDLAT(MDLAT), .CNTW(CNTW), .ZEROREG(1)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
        .mdstartE(mdstartE), .clrcnt(clrcnt),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushE(flushE), .flushM(flushM),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mdbusy(mdbusy), .mddone(mddone), .stallcnt(stallcnt)
    );

    typedef struct packed {
        logic            stallF, stallD, stallE, flushE, flushM;
        logic            fAD, fBD;
        logic [1:0]      fAE, fBE;
        logic            mdbusy, mddone;
        logic [CNTW-1:0] cnt;
    } outs_t;

    outs_t expQ[$];
    int    checks = 0;
    int    errors = 0;
    // mPhase: 0 = no op; k = k-th cycle of the current op (MDLAT+1 = release)
    int    mPhase = 0;
    int    mCnt   = 0;

    function automatic logic m(input logic [REGW-1:0] a, input logic [REGW-1:0] b);
        return (a == b) && (a != 0);
    endfunction

    function automatic outs_t model();
        outs_t e;
        logic  lw, br, md;
        lw = memtoregE && (m(rtE, rsD) || m(rtE, rtD));
        br = branchD && ((regwriteE && (m(writeregE, rsD) || m(writeregE, rtD))) ||
                         (memtoregM && (m(writeregM, rsD) || m(writeregM, rtD))));
        md = (mPhase == 0) ? mdstartE : (mPhase <= MDLAT);
        e.stallF = lw | br | md;
        e.stallD = lw | br | md;
        e.stallE = md;
        e.flushM = md;
        e.flushE = (lw | br) & ~md;
        e.fAD    = regwriteM && m(rsD, writeregM);
        e.fBD    = regwriteM && m(rtD, writeregM);
        e.fAE    = (regwriteM && m(rsE, writeregM)) ? 2'b10 :
                   (regwriteW && m(rsE, writeregW)) ? 2'b01 : 2'b00;
        e.fBE    = (regwriteM && m(rtE, writeregM)) ? 2'b10 :
                   (regwriteW && m(rtE, writeregW)) ? 2'b01 : 2'b00;
        e.mdbusy = md;
        e.mddone = (mPhase == MDLAT + 1);
        e.cnt    = CNTW'(mCnt);
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        outs_t e, o;
        expQ.push_back(model());
        #1;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = expQ.pop_front();
            o = '{stallF, stallD, stallE, flushE, flushM, forwardAD, forwardBD,
                  forwardAE, forwardBE, mdbusy, mddone, stallcnt};
            cmp({tag, ".stallF"}, 8'(o.stallF), 8'(e.stallF));
            cmp({tag, ".stallD"}, 8'(o.stallD), 8'(e.stallD));
            cmp({tag, ".stallE"}, 8'(o.stallE), 8'(e.stallE));
            cmp({tag, ".flushE"}, 8'(o.flushE), 8'(e.flushE));
            cmp({tag, ".flushM"}, 8'(o.flushM), 8'(e.flushM));
            cmp({tag, ".fwdAD"},  8'(o.fAD),    8'(e.fAD));
            cmp({tag, ".fwdBD"},  8'(o.fBD),    8'(e.fBD));
            cmp({tag, ".fwdAE"},  8'(o.fAE),    8'(e.fAE));
            cmp({tag, ".fwdBE"},  8'(o.fBE),    8'(e.fBE));
            cmp({tag, ".mdbusy"}, 8'(o.mdbusy), 8'(e.mdbusy));
            cmp({tag, ".mddone"}, 8'(o.mddone), 8'(e.mddone));
            cmp({tag, ".cnt"},    8'(o.cnt),    8'(e.cnt));
        end
    endtask

    // Advance one clock: model next state from the inputs held across the edge.
    task automatic tick();
        int   nPhase, nCnt;
        logic sF;
        sF = model().stallF;
        if (mPhase == 0)              nPhase = mdstartE ? 2 : 0;
        else if (mPhase == MDLAT + 1) nPhase = 0;
        else                          nPhase = mPhase + 1;
        if (clrcnt)                               nCnt = 0;
        else if (sF && mCnt < (2 ** CNTW) - 1)    nCnt = mCnt + 1;
        else                                      nCnt = mCnt;
        if (reset) begin
            nPhase = 0;
            nCnt   = 0;
        end
        @(posedge clk);
        mPhase = nPhase;
        mCnt   = nCnt;
        #1;
    endtask

    task automatic clearInputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0; branchD = 1'b0;
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        check("rst");
        cmp("rst.cnt0", 8'(stallcnt), 8'd0);
        tick();
        check("rstHold");
        tick();
        reset = 1'b0;
        check("idle");

        // Load-use stall, then release
        memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
        check("lu");
        cmp("lu.stallF", 8'(stallF), 8'd1);
        cmp("lu.flushE", 8'(flushE), 8'd1);
        cmp("lu.stallE", 8'(stallE), 8'd0);
        tick();
        memtoregE = 1'b0;
        check("luOff");
        cmp("luOff.stallF", 8'(stallF), 8'd0);
        cmp("luOff.cnt", 8'(stallcnt), 8'd1);
        clearInputs();

        // Forwarding priority and register zero
        regwriteM = 1'b1; regwriteW = 1'b1;
        writeregM = 5'd7; writeregW = 5'd7; rsE = 5'd7;
        check("fwdM");
        cmp("fwdM.AE", 8'(forwardAE), 8'd2);
        rsE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
        check("fwdZero");
        cmp("fwdZero.AE", 8'(forwardAE), 8'd0);
        rsE = 5'd3; writeregW = 5'd3; writeregM = 5'd4; rtE = 5'd4;
        check("fwdW");
        cmp("fwdW.AE", 8'(forwardAE), 8'd1);
        cmp("fwdW.BE", 8'(forwardBE), 8'd2);
        rsD = 5'd4; rtD = 5'd3;
        check("fwdD");
        cmp("fwdD.AD", 8'(forwardAD), 8'd1);
        tick();
        clearInputs();

        // Branch stalls from E and from a load in M
        branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd9; rtD = 5'd9; rsD = 5'd2;
        check("brE");
        cmp("brE.flushE", 8'(flushE), 8'd1);
        regwriteE = 1'b0; memtoregM = 1'b1; writeregM = 5'd2;
        check("brM");
        cmp("brM.stallD", 8'(stallD), 8'd1);
        branchD = 1'b0;
        check("brOff");
        tick();
        clearInputs();

        // Counter clear
        clrcnt = 1'b1;
        tick();
        clrcnt = 1'b0;
        check("clr");
        cmp("clr.cnt", 8'(stallcnt), 8'd0);

        // Multicycle op with a load-use hazard overlapping the busy period
        mdstartE = 1'b1;
        for (int i = 1; i <= MDLAT + 1; i++) begin
            if (i == 2) begin memtoregE = 1'b1; rtE = 5'd6; rsD = 5'd6; end
            if (i == 3) memtoregE = 1'b0;
            check($sformatf("md%0d", i));
            if (i <= MDLAT) cmp($sformatf("md%0d.stallE", i), 8'(stallE), 8'd1);
            if (i == 2)     cmp("md2.flushE", 8'(flushE), 8'd0);
            if (i == MDLAT + 1) begin
                cmp("mdRel.done", 8'(mddone), 8'd1);
                cmp("mdRel.stallE", 8'(stallE), 8'd0);
                cmp("mdRel.cnt", 8'(stallcnt), 8'd4);
                mdstartE = 1'b0;
            end
            tick();
        end
        clearInputs();
        check("mdIdle");

        // Reset two cycles into BUSY, then a fresh full-length op
        mdstartE = 1'b1;
        check("rb1");
        tick();
        mdstartE = 1'b0;
        check("rb2");
        tick();
        check("rb3");
        reset = 1'b1;
        mPhase = 0;
        mCnt = 0;
        check("rbRst");
        cmp("rbRst.busy", 8'(mdbusy), 8'd0);
        cmp("rbRst.cnt", 8'(stallcnt), 8'd0);
        tick();
        reset = 1'b0;
        mdstartE = 1'b1;
        for (int i = 1; i <= MDLAT + 1; i++) begin
            check($sformatf("rbNew%0d", i));
            cmp($sformatf("rbNew%0d.busy", i), 8'(mdbusy), (i <= MDLAT) ? 8'd1 : 8'd0);
            if (i == MDLAT + 1) mdstartE = 1'b0;
            tick();
        end

        // Saturation and clear-over-increment
        clrcnt = 1'b1;
        tick();
        clrcnt = 1'b0;
        memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("sat%0d", i));
            tick();
        end
        check("satEnd");
        cmp("sat.cnt", 8'(stallcnt), 8'd15);
        clrcnt = 1'b1;
        tick();
        clrcnt = 1'b0;
        check("clrWin");
        cmp("clrWin.cnt", 8'(stallcnt), 8'd0);
        clearInputs();
        tick();
        check("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_pipe.md
HAZARD_CTRL_PIPE -- requirements
Module: hazard_ctrl_pipe

Interface
REQ-001 Parameter REGW, default 5: register-address width.
REQ-002 Parameter MDLAT, default 4: multiply/divide execute latency in cycles; legal range 2..16.
REQ-003 Parameter CNTW, default 16: stall-counter width.
REQ-004 Parameter ZEROREG, default 1: when 1, register address 0 never matches for forwarding or hazard detection.
REQ-005 Clocking and reset: one clock, clk; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 rsD, rtD  in  REGW  decode-stage source addresses.
REQ-009 rsE, rtE, writeregE  in  REGW  execute-stage sources and destination.
REQ-010 writeregM, writeregW  in  REGW  memory- and writeback-stage destinations.
REQ-011 regwriteE, regwriteM, regwriteW  in  1  per-stage register-write enables.
REQ-012 memtoregE, memtoregM  in  1  load in E or M.
REQ-013 branchD  in  1  branch compare active in D.
REQ-014 mdstartE  in  1  multicycle multiply/divide op occupies E.
REQ-015 clrcnt  in  1  synchronous stall-counter clear.
REQ-016 stallF, stallD, stallE  out  1  hold the F, D and E pipeline registers.
REQ-017 flushE, flushM  out  1  insert a bubble into the E or M register.
REQ-018 forwardAD, forwardBD  out  1  forward aluoutM to the D compare operands; 1 = aluoutM.
REQ-019 forwardAE, forwardBE  out  2  E operand select: 00 = regfile, 01 = resultW, 10 = aluoutM; 11 is never driven.
REQ-020 mdbusy  out  1  multicycle unit holding the pipe.
REQ-021 mddone  out  1  one-cycle pulse on the release cycle.
REQ-022 stallcnt  out  CNTW  count of cycles with stallF asserted.

Function
REQ-023 match(a,b) SHALL be (a==b) AND NOT (ZEROREG AND a==0).
REQ-024 forwardAE SHALL be 10 if regwriteM and match(rsE,writeregM); else 01 if regwriteW and match(rsE,writeregW); else 00. M has priority over W. forwardBE is identical using rtE.
REQ-025 forwardAD SHALL equal regwriteM AND match(rsD,writeregM); forwardBD is identical using rtD.
REQ-026 lwstall SHALL equal memtoregE AND (match(rtE,rsD) OR match(rtE,rtD)).
REQ-027 brstall SHALL be asserted when branchD is high and either condition holds:
- regwriteE AND writeregE matches rsD or rtD;
- memtoregM AND writeregM matches rsD or rtD.
REQ-028 The MD FSM SHALL have states IDLE and BUSY, with a counter of ceil(log2(MDLAT)) bits.
REQ-029 In IDLE with mdstartE=1: mdstall=1; at the clock edge, load the counter with MDLAT-1 and go to BUSY.
REQ-030 In BUSY with counter != 0: mdstall=1; decrement at the clock edge; mdstartE is ignored.
REQ-031 In BUSY with counter == 0: mdstall=0 and mddone=1; go to IDLE at the clock edge.
REQ-032 Total stall per MD op SHALL be exactly MDLAT cycles; mddone SHALL assert for exactly one cycle.
REQ-033 mdbusy SHALL equal mdstall.
REQ-034 stallF = stallD = lwstall OR brstall OR mdstall.
REQ-035 stallE = flushM = mdstall.
REQ-036 flushE SHALL equal (lwstall OR brstall) AND NOT mdstall; mdstall overrides because E is held.
REQ-037 All outputs except the FSM state, counter and stallcnt SHALL be combinational, with zero-cycle latency.
REQ-038 stallcnt SHALL increment by 1 at each edge where stallF=1 and saturate at all-ones.
REQ-039 clrcnt=1 SHALL set stallcnt to 0 at the next edge; clear wins over a simultaneous increment.

Reset
REQ-040 reset=1 SHALL immediately force state IDLE, counter 0 and stallcnt 0, independent of clk; this includes reset mid-BUSY.
REQ-041 mddone SHALL be 0 during reset; combinational outputs SHALL follow their inputs.
REQ-042 After reset deasserts, a held-high mdstartE SHALL start a fresh MDLAT-cycle stall.

Verification
REQ-043 Load-use: memtoregE=1, rtE=5, rsD=5 -> stallF=stallD=flushE=1, stallE=0; one cycle later with memtoregE=0 -> all 0.
REQ-044 Forward priority: regwriteM=regwriteW=1, writeregM=writeregW=rsE=7 -> forwardAE=10. With rsE=0 and ZEROREG=1 -> forwardAE=00.
REQ-045 MD latency: MDLAT=4, mdstartE held high -> stallE/flushM high for exactly 4 cycles, mddone on cycle 5, and stallcnt +4.
REQ-046 MD priority: with lwstall also true during BUSY -> flushE=0 while mdbusy=1.
REQ-047 Reset mid-operation: reset pulse 2 cycles into BUSY -> mdbusy=0 and stallcnt=0 immediately; a new op after reset stalls for the full 4 cycles.
REQ-048 Counter: CNTW=4 with stallF held 20 cycles -> stallcnt=15 (saturated); clrcnt together with stallF -> stallcnt=0.
